// File: rtl/cache_def_pkg.sv
// Shared cache-subsystem definitions: arbiter FSM states, request sources and
// line-offset helpers used by the memory port arbiter.
package cache_def;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_IC = 2'd1,
    GNT_DC = 2'd2
  } arb_state_e;

  typedef enum logic {
    IC = 1'b0,
    DC = 1'b1
  } arb_src_e;

  // Number of byte-offset bits inside one line of line_w bits.
  function automatic int line_off_w(input int line_w);
    return $clog2(line_w / 8);
  endfunction

  localparam int LINE_OFF_W = line_off_w(128);

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker. Bit 0 is the I-cache, bit 1 the D-cache; the
// remembered last_grant flips priority on contention and updates on i_take.
module rr_arb2
  import cache_def::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_req,
  input  logic       i_take,
  output logic [1:0] o_gnt
);

  arb_src_e r_last;

  always_comb begin
    o_gnt = 2'b00;
    unique case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = (r_last == IC) ? 2'b10 : 2'b01;
      default: o_gnt = 2'b00;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_last <= IC;
    end else if (i_take && (o_gnt != 2'b00)) begin
      r_last <= o_gnt[1] ? DC : IC;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the line-refill memory port between the I-cache and D-cache miss
// paths, one transaction at a time. Define MEM_ARB_PERF_EN for perf counters.
module mem_port_arbiter
  import cache_def::*;
#(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128
`ifdef MEM_ARB_PERF_EN
  ,
  parameter int CNT_W  = 32
`endif
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ic_cs_i,
  input  logic [ADDR_W-1:0] ic_addr_i,
  output logic [LINE_W-1:0] ic_rdata_o,
  output logic              ic_rvalid_o,
  input  logic              dc_cs_i,
  input  logic              dc_we_i,
  input  logic [ADDR_W-1:0] dc_addr_i,
  input  logic [LINE_W-1:0] dc_wdata_i,
  output logic [LINE_W-1:0] dc_rdata_o,
  output logic              dc_rvalid_o,
  output logic              mem_cs_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_wdata_o,
  input  logic [LINE_W-1:0] mem_rdata_i,
  input  logic              mem_rvalid_i,
  output logic              busy_o
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [CNT_W-1:0]  perf_ic_gnt_o,
  output logic [CNT_W-1:0]  perf_dc_gnt_o,
  output logic [CNT_W-1:0]  perf_wait_o
`endif
);

  localparam int OFF_W = line_off_w(LINE_W);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << OFF_W) - 64'd1);

  // Handshake: a requester raises cs and holds it until its rvalid pulse;
  // mem_cs_o is held until mem_rvalid_i, which completes the transaction.
  arb_state_e r_state;
  arb_state_e w_state_nxt;
  logic [1:0] w_gnt;
  logic       w_idle;
  logic       w_grant_evt;
  logic       r_mem_cs;
  logic       r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [LINE_W-1:0] r_mem_wdata;

  assign w_idle      = (r_state == IDLE);
  assign w_grant_evt = w_idle && (w_gnt != 2'b00);

  rr_arb2 u_rr_arb2 (
    .i_clk  (clk_i),
    .i_rst  (rst_i),
    .i_req  ({dc_cs_i, ic_cs_i}),
    .i_take (w_idle),
    .o_gnt  (w_gnt)
  );

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_gnt[1])      w_state_nxt = GNT_DC;
        else if (w_gnt[0]) w_state_nxt = GNT_IC;
      end
      GNT_IC, GNT_DC: begin
        if (mem_rvalid_i) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // The port is loaded only on the grant edge, so requester changes mid-grant
  // never reach the memory side.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_mem_cs    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else if (w_grant_evt) begin
      r_mem_cs    <= 1'b1;
      r_mem_we    <= w_gnt[1] & dc_we_i;
      r_mem_addr  <= (w_gnt[1] ? dc_addr_i : ic_addr_i) & ~OFF_MASK;
      r_mem_wdata <= w_gnt[1] ? dc_wdata_i : '0;
    end else if (!w_idle && mem_rvalid_i) begin
      r_mem_cs <= 1'b0;
      r_mem_we <= 1'b0;
    end
  end

  assign mem_cs_o    = r_mem_cs;
  assign mem_we_o    = r_mem_we;
  assign mem_addr_o  = r_mem_addr;
  assign mem_wdata_o = r_mem_wdata;
  assign busy_o      = !w_idle;

  assign ic_rdata_o  = mem_rdata_i;
  assign dc_rdata_o  = mem_rdata_i;
  assign ic_rvalid_o = (r_state == GNT_IC) && mem_rvalid_i;
  assign dc_rvalid_o = (r_state == GNT_DC) && mem_rvalid_i;

`ifdef MEM_ARB_PERF_EN
  logic [CNT_W-1:0] r_perf_ic;
  logic [CNT_W-1:0] r_perf_dc;
  logic [CNT_W-1:0] r_perf_wait;
  logic             w_ic_wait;
  logic             w_dc_wait;

  // A side waits when it requests but neither holds nor is receiving the grant.
  assign w_ic_wait = ic_cs_i && (r_state != GNT_IC) && !(w_grant_evt && w_gnt[0]);
  assign w_dc_wait = dc_cs_i && (r_state != GNT_DC) && !(w_grant_evt && w_gnt[1]);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_perf_ic   <= '0;
      r_perf_dc   <= '0;
      r_perf_wait <= '0;
    end else begin
      if (w_grant_evt && w_gnt[0]) r_perf_ic <= r_perf_ic + 1'b1;
      if (w_grant_evt && w_gnt[1]) r_perf_dc <= r_perf_dc + 1'b1;
      r_perf_wait <= r_perf_wait + CNT_W'(w_ic_wait) + CNT_W'(w_dc_wait);
    end
  end

  assign perf_ic_gnt_o = r_perf_ic;
  assign perf_dc_gnt_o = r_perf_dc;
  assign perf_wait_o   = r_perf_wait;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (default and
// MEM_ARB_PERF_EN builds).
module tb_mem_port_arbiter;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 128;

  logic              clk;
  logic              rst;
  logic              ic_cs;
  logic [ADDR_W-1:0] ic_addr;
  logic [LINE_W-1:0] ic_rdata;
  logic              ic_rvalid;
  logic              dc_cs;
  logic              dc_we;
  logic [ADDR_W-1:0] dc_addr;
  logic [LINE_W-1:0] dc_wdata;
  logic [LINE_W-1:0] dc_rdata;
  logic              dc_rvalid;
  logic              mem_cs;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_rvalid;
  logic              busy;
`ifdef MEM_ARB_PERF_EN
  logic [31:0]       perf_ic;
  logic [31:0]       perf_dc;
  logic [31:0]       perf_wait;
`endif

  int errors = 0;
  int checks = 0;

  localparam logic [LINE_W-1:0] PAT_A5 = {16{8'hA5}};
  localparam logic [LINE_W-1:0] PAT_WB = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;

  mem_port_arbiter dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .ic_cs_i      (ic_cs),
    .ic_addr_i    (ic_addr),
    .ic_rdata_o   (ic_rdata),
    .ic_rvalid_o  (ic_rvalid),
    .dc_cs_i      (dc_cs),
    .dc_we_i      (dc_we),
    .dc_addr_i    (dc_addr),
    .dc_wdata_i   (dc_wdata),
    .dc_rdata_o   (dc_rdata),
    .dc_rvalid_o  (dc_rvalid),
    .mem_cs_o     (mem_cs),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_rdata_i  (mem_rdata),
    .mem_rvalid_i (mem_rvalid),
    .busy_o       (busy)
`ifdef MEM_ARB_PERF_EN
    ,
    .perf_ic_gnt_o(perf_ic),
    .perf_dc_gnt_o(perf_dc),
    .perf_wait_o  (perf_wait)
`endif
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs,
                     input logic [LINE_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Completes the current grant: rvalid this cycle, then the idle cycle.
  task automatic mem_complete(input logic [LINE_W-1:0] data, input logic exp_ic,
                              input logic exp_dc, input string tag);
    mem_rdata  = data;
    mem_rvalid = 1'b1;
    #1;
    chk({tag, "_ic_rvalid"}, LINE_W'(ic_rvalid), LINE_W'(exp_ic));
    chk({tag, "_dc_rvalid"}, LINE_W'(dc_rvalid), LINE_W'(exp_dc));
    chk({tag, "_ic_rdata"}, ic_rdata, data);
    chk({tag, "_dc_rdata"}, dc_rdata, data);
  endtask

  initial begin
    rst = 1'b1; ic_cs = 1'b0; ic_addr = '0; dc_cs = 1'b0; dc_we = 1'b0;
    dc_addr = '0; dc_wdata = '0; mem_rdata = '0; mem_rvalid = 1'b0;
    repeat (2) tick;
    chk("rst_mem_cs", LINE_W'(mem_cs), '0);
    chk("rst_mem_we", LINE_W'(mem_we), '0);
    chk("rst_mem_addr", LINE_W'(mem_addr), '0);
    chk("rst_mem_wdata", mem_wdata, '0);
    chk("rst_busy", LINE_W'(busy), '0);
    chk("rst_rvalid", LINE_W'({ic_rvalid, dc_rvalid}), '0);
    rst = 1'b0;
    tick;

    // Single I-cache read
    ic_cs = 1'b1; ic_addr = 32'h0000_104C;
    #1;
    chk("ic_latency_cs0", LINE_W'(mem_cs), '0);
    tick;
    chk("ic_mem_cs", LINE_W'(mem_cs), 1);
    chk("ic_mem_addr", LINE_W'(mem_addr), LINE_W'(32'h0000_1040));
    chk("ic_mem_we", LINE_W'(mem_we), '0);
    chk("ic_mem_wdata", mem_wdata, '0);
    chk("ic_busy", LINE_W'(busy), 1);
    tick;
    chk("ic_hold_cs", LINE_W'(mem_cs), 1);
    mem_complete(PAT_A5, 1'b1, 1'b0, "ic_rd");
    tick;
    mem_rvalid = 1'b0; ic_cs = 1'b0;
    #1;
    chk("ic_pulse_end", LINE_W'(ic_rvalid), '0);
    chk("ic_done_cs", LINE_W'(mem_cs), '0);
    chk("ic_done_busy", LINE_W'(busy), '0);
    tick;

    // D-cache writeback with 5-cycle memory delay and mid-grant input change
    dc_cs = 1'b1; dc_we = 1'b1; dc_addr = 32'h2000_0010; dc_wdata = PAT_WB;
    tick;
    chk("dc_mem_cs", LINE_W'(mem_cs), 1);
    chk("dc_mem_we", LINE_W'(mem_we), 1);
    chk("dc_mem_addr", LINE_W'(mem_addr), LINE_W'(32'h2000_0010));
    chk("dc_mem_wdata", mem_wdata, PAT_WB);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        dc_addr = 32'hDEAD_0000; dc_wdata = ~PAT_WB; dc_we = 1'b0;
      end
      tick;
      chk("dc_hold_cs", LINE_W'(mem_cs), 1);
      chk("dc_hold_we", LINE_W'(mem_we), 1);
      chk("dc_hold_addr", LINE_W'(mem_addr), LINE_W'(32'h2000_0010));
      chk("dc_hold_wdata", mem_wdata, PAT_WB);
    end
    mem_complete('0, 1'b0, 1'b1, "dc_wb");
    tick;
    mem_rvalid = 1'b0; dc_cs = 1'b0; dc_we = 1'b0;
    #1;
    chk("dc_done_cs", LINE_W'(mem_cs), '0);
    chk("dc_done_we", LINE_W'(mem_we), '0);
    chk("dc_pulse_end", LINE_W'(dc_rvalid), '0);
    tick;

    // Asynchronous reset in the middle of an I-cache grant
    ic_cs = 1'b1; ic_addr = 32'h5000_0008;
    tick;
    chk("rg_mem_cs", LINE_W'(mem_cs), 1);
    chk("rg_mem_addr", LINE_W'(mem_addr), LINE_W'(32'h5000_0000));
    #3;
    rst = 1'b1; ic_cs = 1'b0;
    #1;
    chk("rg_async_cs", LINE_W'(mem_cs), '0);
    chk("rg_async_addr", LINE_W'(mem_addr), '0);
    chk("rg_async_busy", LINE_W'(busy), '0);
    tick;
    rst = 1'b0;
    tick;
    mem_complete(PAT_A5, 1'b0, 1'b0, "rg_late");
    chk("rg_late_busy", LINE_W'(busy), '0);
    tick;
    mem_rvalid = 1'b0;
    #1;
    chk("rg_stay_idle", LINE_W'(busy), '0);
    chk("rg_stay_cs", LINE_W'(mem_cs), '0);

    // Spurious completion while idle
    mem_complete(~PAT_A5, 1'b0, 1'b0, "spur");
    tick;
    mem_rvalid = 1'b0;
    #1;
    chk("spur_idle", LINE_W'(busy), '0);

    // Contention from reset: DC, IC, DC with one idle cycle between grants
    ic_cs = 1'b1; ic_addr = 32'h3000_0000;
    dc_cs = 1'b1; dc_we = 1'b0; dc_addr = 32'h4000_0000; dc_wdata = '0;
    tick;
    chk("ct1_cs", LINE_W'(mem_cs), 1);
    chk("ct1_addr_dc", LINE_W'(mem_addr), LINE_W'(32'h4000_0000));
    tick;
    mem_complete('0, 1'b0, 1'b1, "ct1");
    tick;
    mem_rvalid = 1'b0;
    #1;
    chk("ct1_gap_cs", LINE_W'(mem_cs), '0);
    chk("ct1_gap_busy", LINE_W'(busy), '0);
    tick;
    chk("ct2_cs", LINE_W'(mem_cs), 1);
    chk("ct2_addr_ic", LINE_W'(mem_addr), LINE_W'(32'h3000_0000));
    tick;
    mem_complete(PAT_A5, 1'b1, 1'b0, "ct2");
    tick;
    mem_rvalid = 1'b0;
    #1;
    chk("ct2_gap_cs", LINE_W'(mem_cs), '0);
    tick;
    chk("ct3_cs", LINE_W'(mem_cs), 1);
    chk("ct3_addr_dc", LINE_W'(mem_addr), LINE_W'(32'h4000_0000));
    tick;
    mem_complete('0, 1'b0, 1'b1, "ct3");
    tick;
    mem_rvalid = 1'b0; ic_cs = 1'b0; dc_cs = 1'b0;
    #1;
    chk("ct3_gap_cs", LINE_W'(mem_cs), '0);
    tick;
    chk("ct_end_idle", LINE_W'(busy), '0);
`ifdef MEM_ARB_PERF_EN
    chk("perf_ic_gnt", LINE_W'(perf_ic), LINE_W'(1));
    chk("perf_dc_gnt", LINE_W'(perf_dc), LINE_W'(2));
    chk("perf_wait", LINE_W'(perf_wait), LINE_W'(9));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
